// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths and the WB->DE register-write bus layout {wr_reg, wregno, regval}.
package regfile_scoreboard_pkg;

    localparam int unsigned DBITS     = 32;
    localparam int unsigned REGNOBITS = 5;
    localparam int unsigned REGWORDS  = 32;
    localparam int unsigned CNTW      = 2;

    localparam int unsigned FROM_WB_TO_DE_WIDTH = 1 + REGNOBITS + DBITS;

    typedef struct packed {
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
        logic [DBITS-1:0]     regval;
    } wb_bus_t;

    function automatic wb_bus_t unpack_wb(input logic [FROM_WB_TO_DE_WIDTH-1:0] bus);
        return wb_bus_t'(bus);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: counts accepted issues up, WB retirements down.
module sb_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned W = CNTW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         wb_hit,
    output logic [W-1:0] cnt,
    output logic         dec,
    output logic         underflow
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        dec       = wb_hit && (cnt_q != '0);
        underflow = wb_hit && (cnt_q == '0);
        cnt_d     = cnt_q;
        // Issue and retire together leave the count unchanged.
        if (inc && !dec && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// DE-side register file with pending-write scoreboard and RAW/saturation stall.
// Optional REGFILE_BYPASS_EN forwards the WB write to reads and hazard checks in the same cycle.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_wregno,
    input  logic [DBITS-1:0]     wb_regval,
    input  logic [REGNOBITS-1:0] rs1,
    input  logic [REGNOBITS-1:0] rs2,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic                 issue_valid,
    input  logic                 issue_wr_reg,
    input  logic [REGNOBITS-1:0] issue_rd,
    output logic [DBITS-1:0]     rs1_val,
    output logic [DBITS-1:0]     rs2_val,
    output logic                 stall,
    output logic                 sb_err,
    output logic [DBITS-1:0]     reg10_val
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    wb_bus_t wb;
    assign wb = unpack_wb({wb_wr_reg, wb_wregno, wb_regval});

    logic [DBITS-1:0] regs_q [REGWORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGWORDS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb.wr_reg && (wb.wregno != '0)) begin
            regs_q[wb.wregno] <= wb.regval;
        end
    end

    logic [REGWORDS-1:0][CNTW-1:0] cnt;
    logic [REGWORDS-1:0][CNTW-1:0] cnt_eff;
    logic [REGWORDS-1:0]           dec_vec;
    logic [REGWORDS-1:0]           uf_vec;
    logic                          issue_accept;

    // x0 has no counter: it is never pending and never underflows.
    assign cnt[0]     = '0;
    assign dec_vec[0] = 1'b0;
    assign uf_vec[0]  = 1'b0;

    for (genvar g = 1; g < REGWORDS; g++) begin : g_cnt
        sb_counter #(
            .W(CNTW)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (issue_accept && issue_wr_reg && (issue_rd == REGNOBITS'(g))),
            .wb_hit   (wb.wr_reg && (wb.wregno == REGNOBITS'(g))),
            .cnt      (cnt[g]),
            .dec      (dec_vec[g]),
            .underflow(uf_vec[g])
        );
    end

    always_comb begin
        for (int r = 0; r < REGWORDS; r++) begin
            cnt_eff[r] = cnt[r] - CNTW'(BypassEn && dec_vec[r]);
        end
    end

    logic hz1, hz2, sat;

    always_comb begin
        hz1          = rs1_used && (rs1 != '0) && (cnt_eff[rs1] != '0);
        hz2          = rs2_used && (rs2 != '0) && (cnt_eff[rs2] != '0);
        // Saturation looks at the raw count: a same-cycle retire does not free a slot.
        sat          = issue_wr_reg && (issue_rd != '0) && (cnt[issue_rd] == '1);
        stall        = issue_valid && (hz1 || hz2 || sat);
        issue_accept = issue_valid && !stall;
    end

    always_comb begin
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
        if (BypassEn && wb.wr_reg && (wb.wregno == rs1) && (rs1 != '0)) begin
            rs1_val = wb.regval;
        end
        if (BypassEn && wb.wr_reg && (wb.wregno == rs2) && (rs2 != '0)) begin
            rs2_val = wb.regval;
        end
    end

    logic sb_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_q | (|uf_vec);
        end
    end

    assign sb_err    = sb_err_q;
    assign reg10_val = regs_q[10];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge monitor compares them.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic        wb_wr_reg;
    logic [4:0]  wb_wregno;
    logic [31:0] wb_regval;
    logic [4:0]  rs1, rs2;
    logic        rs1_used, rs2_used;
    logic        issue_valid, issue_wr_reg;
    logic [4:0]  issue_rd;
    logic [31:0] rs1_val, rs2_val, reg10_val;
    logic        stall, sb_err;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .wb_wr_reg   (wb_wr_reg),
        .wb_wregno   (wb_wregno),
        .wb_regval   (wb_regval),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .issue_valid (issue_valid),
        .issue_wr_reg(issue_wr_reg),
        .issue_rd    (issue_rd),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .stall       (stall),
        .sb_err      (sb_err),
        .reg10_val   (reg10_val)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam bit [4:0] M_ST = 5'd1, M_R1 = 5'd2, M_R2 = 5'd4, M_ER = 5'd8, M_R10 = 5'd16;

    typedef struct {
        string       name;
        bit [4:0]    mask;
        logic        st;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        er;
        logic [31:0] r10;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string n, input string f, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", n, f, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.mask[0]) cmp(mon_e.name, "stall", 32'(stall), 32'(mon_e.st));
            if (mon_e.mask[1]) cmp(mon_e.name, "rs1_val", rs1_val, mon_e.r1);
            if (mon_e.mask[2]) cmp(mon_e.name, "rs2_val", rs2_val, mon_e.r2);
            if (mon_e.mask[3]) cmp(mon_e.name, "sb_err", 32'(sb_err), 32'(mon_e.er));
            if (mon_e.mask[4]) cmp(mon_e.name, "reg10_val", reg10_val, mon_e.r10);
        end
    end

    task automatic expect_out(input string n, input bit [4:0] m, input logic st,
                              input logic [31:0] r1, input logic [31:0] r2, input logic er,
                              input logic [31:0] r10);
        exp_t e;
        e.name = n; e.mask = m; e.st = st; e.r1 = r1; e.r2 = r2; e.er = er; e.r10 = r10;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        reset = 1'b0; wb_wr_reg = 1'b0; wb_wregno = '0; wb_regval = '0;
        rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        issue_valid = 1'b0; issue_wr_reg = 1'b0; issue_rd = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        wb_wr_reg = 1'b1; wb_wregno = r; wb_regval = v;
    endtask

    task automatic iss_wr(input logic [4:0] rd);
        issue_valid = 1'b1; issue_wr_reg = 1'b1; issue_rd = rd;
    endtask

    task automatic reader(input logic [4:0] a, input logic ua, input logic [4:0] b,
                          input logic ub);
        issue_valid = 1'b1; rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b1;
        cyc();

        // Reset state
        rs1 = 5'd5; rs2 = 5'd10;
        expect_out("reset", M_ST | M_R1 | M_R2 | M_ER | M_R10, 0, 0, 0, 0, 0);
        cyc();

        // 1: write/read-back, x0 write dropped
        iss_wr(5'd5);
        expect_out("t1_issue", M_ST, 0, 0, 0, 0, 0);
        cyc();
        wb(5'd5, 32'h1234); rs1 = 5'd5;
        cyc();
        wb(5'd0, 32'hFF); rs1 = 5'd5; rs2 = 5'd0;
        expect_out("t1_read", M_R1 | M_R2 | M_ER, 0, 32'h1234, 0, 0, 0);
        cyc();
        rs2 = 5'd0;
        expect_out("t1_x0", M_R2 | M_ER, 0, 0, 0, 0, 0);
        cyc();

        // 2: RAW stall
        iss_wr(5'd3);
        expect_out("t2_issue", M_ST, 0, 0, 0, 0, 0);
        cyc();
        reader(5'd0, 0, 5'd3, 1);
        expect_out("t2_raw", M_ST, 1, 0, 0, 0, 0);
        cyc();
        reader(5'd0, 0, 5'd3, 1); wb(5'd3, 32'd7);
        expect_out("t2_wb", M_ST | M_R2, !BYP, 0, BYP ? 32'd7 : 32'd0, 0, 0);
        cyc();
        reader(5'd0, 0, 5'd3, 1);
        expect_out("t2_after", M_ST | M_R2, 0, 0, 32'd7, 0, 0);
        cyc();

        // 3: saturation at 3 in flight
        for (int i = 0; i < 3; i++) begin
            iss_wr(5'd8);
            expect_out("t3_fill", M_ST, 0, 0, 0, 0, 0);
            cyc();
        end
        iss_wr(5'd8);
        expect_out("t3_sat", M_ST, 1, 0, 0, 0, 0);
        cyc();
        iss_wr(5'd8);
        expect_out("t3_sat_hold", M_ST, 1, 0, 0, 0, 0);
        cyc();
        wb(5'd8, 32'h88);
        cyc();
        iss_wr(5'd8);
        expect_out("t3_refill", M_ST, 0, 0, 0, 0, 0);
        cyc();

        // 4: simultaneous inc/dec on x4
        iss_wr(5'd4);
        expect_out("t4_issue", M_ST, 0, 0, 0, 0, 0);
        cyc();
        iss_wr(5'd4); wb(5'd4, 32'd9);
        expect_out("t4_both", M_ST, 0, 0, 0, 0, 0);
        cyc();
        reader(5'd4, 1, 5'd0, 0);
        expect_out("t4_still_pending", M_ST | M_R1, 1, 32'd9, 0, 0, 0);
        cyc();
        reader(5'd4, 1, 5'd0, 0); wb(5'd4, 32'd9);
        expect_out("t4_retire", M_ST | M_R1, !BYP, 32'd9, 0, 0, 0);
        cyc();
        reader(5'd4, 1, 5'd0, 0);
        expect_out("t4_clear", M_ST | M_R1, 0, 32'd9, 0, 0, 0);
        cyc();

        // 5: underflow is sticky until reset
        wb(5'd6, 32'hA); rs1 = 5'd6;
        expect_out("t5_pre", M_ER, 0, 0, 0, 0, 0);
        cyc();
        rs1 = 5'd6;
        expect_out("t5_uf", M_ER | M_R1, 0, 32'hA, 0, 1, 0);
        cyc();
        expect_out("t5_sticky", M_ER, 0, 0, 0, 1, 0);
        cyc();
        reset = 1'b1;
        cyc();
        rs1 = 5'd6;
        expect_out("t5_reset", M_ER | M_R1, 0, 0, 0, 0, 0);
        cyc();

        // 6: x10 status and reset mid-stall
        wb(5'd10, 32'd1);
        expect_out("t6_r10_same", M_R10, 0, 0, 0, 0, 0);
        cyc();
        expect_out("t6_r10_next", M_R10, 0, 0, 0, 0, 32'd1);
        cyc();
        iss_wr(5'd12);
        cyc();
        reader(5'd12, 1, 5'd0, 0);
        expect_out("t6_stalled", M_ST, 1, 0, 0, 0, 32'd1);
        cyc();
        reader(5'd12, 1, 5'd0, 0); reset = 1'b1;
        cyc();
        reader(5'd12, 1, 5'd8, 1);
        expect_out("t6_post_reset", M_ST | M_ER | M_R10, 0, 0, 0, 0, 0);
        cyc();
        wb(5'd12, 32'h5);
        expect_out("t6_late_wb", M_ER, 0, 0, 0, 0, 0);
        cyc();
        expect_out("t6_late_err", M_ER, 0, 0, 0, 1, 0);
        cyc();

        @(negedge clk);
        #1;
        cmp("drain", "queue_left", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
